// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - ALU/load result buffering and round-robin arbitration onto the reg_file write port
module writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_val,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  input  logic [2:0]  ld_funct3,
  output logic        write_sig,
  output logic [4:0]  write_reg,
  output logic [63:0] write_val,
  output logic [31:0] pending_mask
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    a_rd_mem  [DEPTH];
  logic [63:0]   a_val_mem [DEPTH];
  logic [AW-1:0] a_wp, a_rp;
  logic [CW-1:0] a_cnt;

  logic [4:0]    l_rd_mem  [DEPTH];
  logic [63:0]   l_val_mem [DEPTH];
  logic [AW-1:0] l_wp, l_rp;
  logic [CW-1:0] l_cnt;

  logic        last_alu;
  logic        a_ne, l_ne;
  logic        a_push, l_push, a_pop, l_pop;
  logic [63:0] ld_ext;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  extend = {{56{d[7]}}, d[7:0]};
      3'b001:  extend = {{48{d[15]}}, d[15:0]};
      3'b010:  extend = {{32{d[31]}}, d[31:0]};
      3'b100:  extend = {56'd0, d[7:0]};
      3'b101:  extend = {48'd0, d[15:0]};
      3'b110:  extend = {32'd0, d[31:0]};
      default: extend = d;
    endcase
  endfunction

  // ready reflects FIFO occupancy only, so a full FIFO refuses even if it pops this cycle
  assign alu_ready = (a_cnt != FULL);
  assign ld_ready  = (l_cnt != FULL);
  assign a_ne      = (a_cnt != '0);
  assign l_ne      = (l_cnt != '0);

  // writes to x0 complete the handshake but are never queued
  assign a_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign l_push = ld_valid && ld_ready && (ld_rd != 5'd0);

  // load wins when alone or when ALU had the previous grant
  assign l_pop  = l_ne && (!a_ne || last_alu);
  assign a_pop  = a_ne && !l_pop;
  assign ld_ext = extend(ld_data, ld_funct3);

  // queue storage; entries outside the valid window are don't-care
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_rd_mem[a_wp]  <= alu_rd;
      a_val_mem[a_wp] <= alu_val;
    end
    if (l_push) begin
      l_rd_mem[l_wp]  <= ld_rd;
      l_val_mem[l_wp] <= ld_ext;
    end
  end

  // queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_wp  <= '0;
      a_rp  <= '0;
      a_cnt <= '0;
      l_wp  <= '0;
      l_rp  <= '0;
      l_cnt <= '0;
    end else begin
      if (a_push) a_wp <= a_wp + AW'(1);
      if (a_pop)  a_rp <= a_rp + AW'(1);
      a_cnt <= a_cnt + CW'(a_push) - CW'(a_pop);
      if (l_push) l_wp <= l_wp + AW'(1);
      if (l_pop)  l_rp <= l_rp + AW'(1);
      l_cnt <= l_cnt + CW'(l_push) - CW'(l_pop);
    end
  end

  // write-port stage: popped head is presented to reg_file for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_sig <= 1'b0;
      write_reg <= '0;
      write_val <= '0;
      last_alu  <= 1'b1;
    end else begin
      write_sig <= a_pop | l_pop;
      if (l_pop) begin
        write_reg <= l_rd_mem[l_rp];
        write_val <= l_val_mem[l_rp];
        last_alu  <= 1'b0;
      end else if (a_pop) begin
        write_reg <= a_rd_mem[a_rp];
        write_val <= a_val_mem[a_rp];
        last_alu  <= 1'b1;
      end
    end
  end

  // destinations of every queued entry plus the one currently on the write port
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < a_cnt) pending_mask[a_rd_mem[a_rp + AW'(k)]] = 1'b1;
      if (CW'(k) < l_cnt) pending_mask[l_rd_mem[l_rp + AW'(k)]] = 1'b1;
    end
    if (write_sig) pending_mask[write_reg] = 1'b1;
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_val;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_funct3;
  logic        write_sig;
  logic [4:0]  write_reg;
  logic [63:0] write_val;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_val(alu_val),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3),
    .write_sig(write_sig), .write_reg(write_reg), .write_val(write_val),
    .pending_mask(pending_mask)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_val = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0; ld_funct3 = '0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [4:0] rd; logic [63:0] val; } ent_t;
  ent_t        qa[$];
  ent_t        ql[$];
  bit          m_last_alu;
  bit          e_sig;
  logic [4:0]  e_reg;
  logic [63:0] e_val;
  int          accepted, writes;
  bit          acc_a, acc_l;

  function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [2:0] f3);
    int bits;
    logic [63:0] m, v;
    bits = 8 << f3[1:0];
    if (f3 == 3'b111) bits = 64;
    m = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v = d & m;
    if (!f3[2] && bits < 64 && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (qa[i]) m[qa[i].rd] = 1'b1;
    foreach (ql[i]) m[ql[i].rd] = 1'b1;
    if (e_sig) m[e_reg] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    qa.delete(); ql.delete();
    m_last_alu = 1'b1; e_sig = 1'b0;
    accepted = 0; writes = 0;
    acc_a = 1'b0; acc_l = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    model_clear();
  endtask

  // one clock with the currently driven inputs, checked against the model
  task automatic cycle();
    ent_t e;
    chk("alu_ready", alu_ready, qa.size() < DEPTH);
    chk("ld_ready", ld_ready, ql.size() < DEPTH);
    acc_a = alu_valid && (qa.size() < DEPTH);
    acc_l = ld_valid && (ql.size() < DEPTH);
    @(posedge clk);
    e_sig = 1'b0;
    if (ql.size() > 0 && (qa.size() == 0 || m_last_alu)) begin
      e = ql.pop_front(); e_sig = 1'b1; e_reg = e.rd; e_val = e.val; m_last_alu = 1'b0;
    end else if (qa.size() > 0) begin
      e = qa.pop_front(); e_sig = 1'b1; e_reg = e.rd; e_val = e.val; m_last_alu = 1'b1;
    end
    if (acc_a && alu_rd != 5'd0) begin
      e.rd = alu_rd; e.val = alu_val; qa.push_back(e); accepted++;
    end
    if (acc_l && ld_rd != 5'd0) begin
      e.rd = ld_rd; e.val = ref_ext(ld_data, ld_funct3); ql.push_back(e); accepted++;
    end
    #1;
    chk("write_sig", write_sig, e_sig);
    if (e_sig) begin
      chk("write_reg", write_reg, e_reg);
      chk("write_val", write_val, e_val);
    end
    chk("pending_mask", pending_mask, model_mask());
    if (write_sig) writes++;
  endtask

  // ---------------- load extension vectors ----------------
  typedef struct { logic [2:0] f3; logic [63:0] data; logic [63:0] exp; } ld_vec_t;
  ld_vec_t vecs[10];

  initial begin
    int w0;
    bit saw_a, saw_l;
    int a_idx, l_idx;

    vecs[0] = '{3'b000, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{3'b100, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080};
    vecs[2] = '{3'b010, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
    vecs[3] = '{3'b110, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000};
    vecs[4] = '{3'b001, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_8000};
    vecs[5] = '{3'b101, 64'hFFFF_FFFF_FFFF_8000, 64'h0000_0000_0000_8000};
    vecs[6] = '{3'b011, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    vecs[7] = '{3'b111, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9};
    vecs[8] = '{3'b000, 64'hAAAA_AAAA_AAAA_AA7F, 64'h0000_0000_0000_007F};
    vecs[9] = '{3'b010, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};

    // T1: reset held with valids high
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_val = 64'h55;
    ld_valid = 1'b1;  ld_rd = 5'd4;  ld_data = 64'h66; ld_funct3 = 3'b011;
    step(); step();
    chk("t1 write_sig", write_sig, 0);
    chk("t1 write_reg", write_reg, 0);
    chk("t1 write_val", write_val, 0);
    chk("t1 mask", pending_mask, 0);
    chk("t1 alu_ready", alu_ready, 1);
    chk("t1 ld_ready", ld_ready, 1);
    idle();
    reset = 1'b1;
    step();

    // T2: single ALU write latency and mask lifetime
    alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 64'h1234;
    step();
    idle();
    chk("t2 sig after E", write_sig, 0);
    chk("t2 mask after E", pending_mask, 32'h20);
    step();
    chk("t2 sig after E+1", write_sig, 1);
    chk("t2 reg", write_reg, 5);
    chk("t2 val", write_val, 64'h1234);
    chk("t2 mask in write", pending_mask, 32'h20);
    step();
    chk("t2 sig after E+2", write_sig, 0);
    chk("t2 mask after", pending_mask, 0);

    // T3: load extension table
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = vecs[i].f3; ld_data = vecs[i].data;
      step();
      idle();
      chk("t3 mask after accept", pending_mask[7], 1);
      step();
      chk("t3 write_sig", write_sig, 1);
      chk("t3 write_reg", write_reg, 7);
      chk("t3 write_val", write_val, vecs[i].exp);
      step();
      chk("t3 sig drop", write_sig, 0);
    end

    // T5: write to x0 is swallowed
    alu_valid = 1'b1; alu_rd = 5'd0; alu_val = 64'hDEAD;
    chk("t5 alu_ready", alu_ready, 1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("t5 write_sig", write_sig, 0);
      chk("t5 mask", pending_mask, 0);
      step();
    end

    // T6: reset asserted mid-cycle with entries queued
    alu_valid = 1'b1; alu_rd = 5'd1; alu_val = 64'h11;
    ld_valid = 1'b1;  ld_rd = 5'd2;  ld_data = 64'h22; ld_funct3 = 3'b011;
    step();
    ld_valid = 1'b0;
    alu_rd = 5'd3; alu_val = 64'h33;
    step();
    idle();
    chk("t6 mask before reset", pending_mask, 32'h0000_000E);
    #3;
    reset = 1'b0;
    #1;
    chk("t6 write_sig", write_sig, 0);
    chk("t6 write_reg", write_reg, 0);
    chk("t6 write_val", write_val, 0);
    chk("t6 mask", pending_mask, 0);
    chk("t6 alu_ready", alu_ready, 1);
    chk("t6 ld_ready", ld_ready, 1);
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6 no write after release", write_sig, 0);
      chk("t6 mask after release", pending_mask, 0);
    end

    // T4: both sources valid every cycle, distinct rd
    do_reset();
    saw_a = 1'b0; saw_l = 1'b0;
    a_idx = 0; l_idx = 0;
    w0 = writes;
    for (int i = 0; i < 20; i++) begin
      if (!alu_valid || acc_a) begin
        alu_rd = 5'(1 + (2 * a_idx) % 30); alu_val = {$urandom, $urandom}; a_idx++;
      end
      if (!ld_valid || acc_l) begin
        ld_rd = 5'(2 + (2 * l_idx) % 30); ld_data = {$urandom, $urandom};
        ld_funct3 = 3'($urandom_range(0, 7)); l_idx++;
      end
      alu_valid = 1'b1; ld_valid = 1'b1;
      if (!alu_ready) saw_a = 1'b1;
      if (!ld_ready) saw_l = 1'b1;
      cycle();
    end
    chk("t4 writes every cycle", writes - w0, 19);
    chk("t4 alu_ready deasserted", saw_a, 1);
    chk("t4 ld_ready deasserted", saw_l, 1);

    // randomized traffic, holding payload while stalled
    for (int i = 0; i < 400; i++) begin
      if (!(alu_valid && !acc_a)) begin
        alu_valid = ($urandom_range(0, 9) < 7);
        alu_rd = 5'($urandom_range(0, 31)); alu_val = {$urandom, $urandom};
      end
      if (!(ld_valid && !acc_l)) begin
        ld_valid = ($urandom_range(0, 9) < 7);
        ld_rd = 5'($urandom_range(0, 31)); ld_data = {$urandom, $urandom};
        ld_funct3 = 3'($urandom_range(0, 7));
      end
      cycle();
    end
    idle();
    for (int i = 0; i < 6; i++) cycle();
    chk("accepted equals written", writes, accepted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
